// File: rtl/fast9_pkg.sv
// FAST-9 arc detector shared types.
// Class codes, ring size and FSM states.
package fast9_pkg;

  localparam int NUM_PTS = 16;

  typedef enum logic [1:0] {
    CLS_SIM    = 2'b00,
    CLS_BRIGHT = 2'b01,
    CLS_DARK   = 2'b10
  } cls_e;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    SCAN,
    DONE
  } state_e;

  function automatic logic [4:0] sat_inc(
    input logic [4:0] v
  );
    return (v >= 5'd16) ? 5'd16 : v + 5'd1;
  endfunction

endpackage

// File: rtl/fast9_arc_if.sv
// Pixel sample bus and result bus between
// the match counter and the arc detector.
interface fast9_arc_if #(
  parameter int PIX_W = 8
);

  logic             pixValid;
  logic [3:0]       pixAddr;
  logic             lastPix;
  logic [PIX_W-1:0] circPix;
  logic [PIX_W-1:0] centerPix;
  logic [PIX_W-1:0] threshold;
  logic             busy;
  logic             resultValid;
  logic             isCorner;
  logic             cornerType;
  logic [4:0]       maxRun;

  modport master (
    output pixValid, pixAddr, lastPix,
    output circPix, centerPix, threshold,
    input  busy, resultValid, isCorner,
    input  cornerType, maxRun
  );

  modport slave (
    input  pixValid, pixAddr, lastPix,
    input  circPix, centerPix, threshold,
    output busy, resultValid, isCorner,
    output cornerType, maxRun
  );

endinterface

// File: rtl/fast9_pixel_classifier.sv
// Bright / dark / similar decision for one
// circle pixel against centre +/- threshold.
module fast9_pixel_classifier
  import fast9_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic [PIX_W-1:0] circPix,
  input  logic [PIX_W-1:0] centerPix,
  input  logic [PIX_W-1:0] threshold,
  output cls_e             cls
);

  logic [PIX_W:0] circ_x;
  logic [PIX_W:0] ctr_x;
  logic [PIX_W:0] thr_x;

  // One extra bit keeps both sums exact.
  always_comb begin
    circ_x = {1'b0, circPix};
    ctr_x  = {1'b0, centerPix};
    thr_x  = {1'b0, threshold};
    cls    = CLS_SIM;
    if (circ_x > ctr_x + thr_x) begin
      cls = CLS_BRIGHT;
    end else if (circ_x + thr_x < ctr_x) begin
      cls = CLS_DARK;
    end
  end

endmodule

// File: rtl/fast9_arc_detector.sv
// Collects 16 classified ring pixels, then scans
// with wrap-around for the longest same-class arc.
module fast9_arc_detector
  import fast9_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int ARC_LEN = 9
) (
  input  logic        clock,
  input  logic        nReset,
  fast9_arc_if.slave  bus
);

  localparam int SCAN_LEN = NUM_PTS + ARC_LEN - 1;
  localparam logic [4:0] LAST_STEP = 5'(SCAN_LEN - 1);
  localparam logic [4:0] ARC_THR   = 5'(ARC_LEN);

  state_e           state_q, state_d;
  cls_e             cls_q [NUM_PTS];
  cls_e             cls_d [NUM_PTS];
  logic [PIX_W-1:0] ctr_q, ctr_d;
  logic [PIX_W-1:0] thr_q, thr_d;
  logic [4:0]       step_q, step_d;
  logic [4:0]       brun_q, brun_d;
  logic [4:0]       drun_q, drun_d;
  logic [4:0]       maxb_q, maxb_d;
  logic [4:0]       maxd_q, maxd_d;
  logic             busy_q, busy_d;
  logic             rvalid_q, rvalid_d;
  logic             corner_q, corner_d;
  logic             ctype_q, ctype_d;
  logic [4:0]       run_q, run_d;

  logic [PIX_W-1:0] cls_ctr;
  logic [PIX_W-1:0] cls_thr;
  cls_e             new_cls;
  cls_e             cur_cls;

  // First sample classifies against live inputs.
  assign cls_ctr = (state_q == IDLE) ?
                   bus.centerPix : ctr_q;
  assign cls_thr = (state_q == IDLE) ?
                   bus.threshold : thr_q;

  fast9_pixel_classifier #(
    .PIX_W (PIX_W)
  ) u_cls (
    .circPix   (bus.circPix),
    .centerPix (cls_ctr),
    .threshold (cls_thr),
    .cls       (new_cls)
  );

  assign cur_cls = cls_q[step_q[3:0]];

  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    ctr_d    = ctr_q;
    thr_d    = thr_q;
    step_d   = step_q;
    brun_d   = brun_q;
    drun_d   = drun_q;
    maxb_d   = maxb_q;
    maxd_d   = maxd_q;
    corner_d = corner_q;
    ctype_d  = ctype_q;
    run_d    = run_q;
    unique case (state_q)
      IDLE: begin
        if (bus.pixValid) begin
          ctr_d  = bus.centerPix;
          thr_d  = bus.threshold;
          step_d = '0;
          brun_d = '0;
          drun_d = '0;
          maxb_d = '0;
          maxd_d = '0;
          for (int i = 0; i < NUM_PTS; i++) begin
            cls_d[i] = CLS_SIM;
          end
          cls_d[bus.pixAddr] = new_cls;
          state_d = bus.lastPix ? SCAN : COLLECT;
        end
      end
      COLLECT: begin
        if (bus.pixValid) begin
          cls_d[bus.pixAddr] = new_cls;
          if (bus.lastPix) begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        brun_d = (cur_cls == CLS_BRIGHT) ?
                 sat_inc(brun_q) : 5'd0;
        drun_d = (cur_cls == CLS_DARK) ?
                 sat_inc(drun_q) : 5'd0;
        maxb_d = (brun_d > maxb_q) ? brun_d : maxb_q;
        maxd_d = (drun_d > maxd_q) ? drun_d : maxd_q;
        step_d = step_q + 5'd1;
        if (step_q == LAST_STEP) begin
          state_d  = DONE;
          corner_d = (maxb_d >= ARC_THR) ||
                     (maxd_d >= ARC_THR);
          ctype_d  = (maxb_d >= ARC_THR);
          run_d    = (maxb_d >= maxd_d) ?
                     maxb_d : maxd_d;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d   = (state_d == SCAN) ||
               (state_d == DONE);
    rvalid_d = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (!nReset) begin
      state_q  <= IDLE;
      cls_q    <= '{default: CLS_SIM};
      ctr_q    <= '0;
      thr_q    <= '0;
      step_q   <= '0;
      brun_q   <= '0;
      drun_q   <= '0;
      maxb_q   <= '0;
      maxd_q   <= '0;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      corner_q <= 1'b0;
      ctype_q  <= 1'b0;
      run_q    <= '0;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      ctr_q    <= ctr_d;
      thr_q    <= thr_d;
      step_q   <= step_d;
      brun_q   <= brun_d;
      drun_q   <= drun_d;
      maxb_q   <= maxb_d;
      maxd_q   <= maxd_d;
      busy_q   <= busy_d;
      rvalid_q <= rvalid_d;
      corner_q <= corner_d;
      ctype_q  <= ctype_d;
      run_q    <= run_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.resultValid = rvalid_q;
  assign bus.isCorner    = corner_q;
  assign bus.cornerType  = ctype_q;
  assign bus.maxRun      = run_q;

endmodule

// File: doc/fast9_arc_detector.md
Name: fast9_arc_detector

Overview:
- Downstream of the match counter stage in the FAST-9 pipeline.
- Accepts the 16 circle pixels of one candidate, addressed 0..15 by the counter's register address.
- Classifies each pixel as bright, dark or similar against centre ± threshold, and stores the class codes.
- After the last pixel, scans the ring with wrap-around for a contiguous arc of at least ARC_LEN same-class pixels, then reports corner / no-corner with the arc type and longest-run length.

Parameters:
- PIX_W, 8, pixel and threshold width.
- ARC_LEN, 9, minimum contiguous run for a corner; legal range 1..16.

Ports:
- clock  in  1  system clock, rising edge.
- nReset  in  1  reset: synchronous, active-low.
- pixValid  in  1  circle pixel sample valid this cycle.
- pixAddr  in  4  circle position 0..15 of the sample (from the counter's posAddr).
- lastPix  in  1  qualifies the final sample of a candidate (from the counter's posReaden); meaningful only with pixValid.
- circPix  in  PIX_W  circle pixel intensity.
- centerPix  in  PIX_W  candidate centre intensity.
- threshold  in  PIX_W  FAST threshold t.
- busy  out  1  high in SCAN and DONE; samples are ignored while high.
- resultValid  out  1  one-cycle pulse carrying the result.
- isCorner  out  1  a run of at least ARC_LEN exists; valid with resultValid.
- cornerType  out  1  1 = bright arc, 0 = dark arc; 0 when isCorner=0.
- maxRun  out  5  longest run of the winning class (bright if maxBright ≥ maxDark, else dark), saturated at 16.

Behaviour:
- Reset (nReset=0 at a clock edge):
  - State goes to IDLE; all 16 class entries are cleared to SIM.
  - Run counters and latched centre/threshold are cleared.
  - busy, resultValid, isCorner, cornerType and maxRun are all 0.
  - Reset mid-COLLECT or mid-SCAN abandons the candidate; no resultValid is issued.
- Classification, per accepted sample:
  - Compare at PIX_W+1 bits; no overflow is possible.
  - BRIGHT if circPix > centerPix + threshold.
  - DARK if circPix + threshold < centerPix.
  - SIM otherwise.
  - Equality with either bound counts as SIM.
- States:
  - IDLE:
    - pixValid latches centerPix and threshold, clears the class array, and writes the first sample's class at pixAddr in the same edge.
    - Go to SCAN if lastPix is also high, else go to COLLECT.
  - COLLECT:
    - Each pixValid writes the class at pixAddr, using the latched centre/threshold. centerPix and threshold inputs are ignored after the first sample.
    - A duplicate address overwrites (last write wins); unwritten addresses stay SIM.
    - pixValid&&lastPix writes the sample, then goes to SCAN.
  - SCAN:
    - Runs exactly 16+ARC_LEN-1 cycles (24 by default). Step k reads entry k mod 16.
    - brightRun increments on BRIGHT, else clears; darkRun likewise for DARK. Both saturate at 16.
    - maxBright and maxDark track their maxima, both saturating at 16.
    - pixValid is ignored.
  - DONE: one cycle. resultValid=1 with the result; return to IDLE. Outputs hold their values until the next DONE, except resultValid.
- Result:
  - isCorner = (maxBright ≥ ARC_LEN) || (maxDark ≥ ARC_LEN). Both cannot hold when ARC_LEN > 8.
  - cornerType = 1 if maxBright ≥ ARC_LEN.
- Latency:
  - The lastPix sample is accepted at edge T.
  - SCAN occupies cycles T+1..T+24.
  - resultValid is high in cycle T+25.
  - A new candidate may start in the cycle after DONE.
- Wrap-around: a run crossing address 15→0 is detected through the ARC_LEN-1 extra scan steps.
- Uniform ring: a ring that is all BRIGHT gives maxRun=16 (saturated), not 24.

Decomposition:
- Package fast9_pkg holds:
  - class codes CLS_SIM=2'b00, CLS_BRIGHT=2'b01, CLS_DARK=2'b10;
  - NUM_PTS=16;
  - state encodings IDLE, COLLECT, SCAN, DONE.
- One sub-module: fast9_pixel_classifier, combinational. Inputs circPix, centerPix, threshold; output is the 2-bit class.

Test Plan:
- Centre 100, t 20. Addresses 0..8 = 130, rest 100, lastPix at addr 15 → resultValid at T+25, isCorner=1, cornerType=1, maxRun=9.
- Centre 100, t 20. Addresses 12..15 and 0..4 = 70 (9 wrapped darks), rest 100 → isCorner=1, cornerType=0, maxRun=9.
- Centre 100, t 20. Eight contiguous 130s, rest 100 → isCorner=0, maxRun=8.
- All 16 = 120 (equal to the bound) → all SIM, isCorner=0, maxRun=0. All 16 = 121 → isCorner=1, maxRun=16.
- Centre 250, t 20, circPix 255 → SIM (no wrap overflow). Centre 10, t 20, circPix 0 → SIM.
- nReset low at SCAN step 10 → no resultValid; busy=0 next cycle. Pixel pulses during SCAN are ignored, and a following clean candidate produces the correct result.
